// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates icache and dcache requests onto a single-port RAM, holding the grant for a
// requester's whole access and trapping RAM errors or stalled accesses into a sticky fault.
module mem_arbiter_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [1:0]       RAM_ERROR  = 2'd3;
    localparam logic             GRANT_I    = 1'b0;
    localparam logic             GRANT_D    = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             last_grant_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic d_req;
    logic ram_access;
    logic ram_error;
    logic timed_out;

    assign d_req      = dREN | dWEN;
    assign ram_access = (ramstate == RAM_ACCESS);
    assign ram_error  = (ramstate == RAM_ERROR);
    assign timed_out  = (cnt == CNT_LAST) && !ram_access;

    // State, round-robin history, stall counter and sticky fault flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            err        <= err | (state_nxt == FAULT);
        end
    end

    // Next-state: grant selection, grant release and fault detection
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // On contention the side that was not served last wins
                if (d_req && (!iREN || (last_grant == GRANT_I))) begin
                    state_nxt = DGRANT;
                end else if (iREN) begin
                    state_nxt = IGRANT;
                end
            end
            DGRANT: begin
                if (ram_error) begin
                    state_nxt = FAULT;
                end else if (!d_req) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = GRANT_D;
                    cnt_nxt        = '0;
                end else if (ram_access) begin
                    cnt_nxt = '0;
                end else if (timed_out) begin
                    state_nxt = FAULT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IGRANT: begin
                if (ram_error) begin
                    state_nxt = FAULT;
                end else if (!iREN || ram_access) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = GRANT_I;
                    cnt_nxt        = '0;
                end else if (timed_out) begin
                    state_nxt = FAULT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase
    end

    // Outputs: RAM side follows the owner's request, waits release only on the owner's ACCESS
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = ramload;
        dload    = ramload;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = !ram_access;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = !ram_access;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: directed scenarios plus randomized traffic
// compared against a request/grant reference model.
module tb_mem_arbiter_ctrl;

    localparam int unsigned TIMEOUT = 64;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam int O_IDLE = 0;
    localparam int O_I    = 1;
    localparam int O_D    = 2;
    localparam int O_F    = 3;
    localparam int L_I    = 0;
    localparam int L_D    = 1;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    int checks;
    int failures;

    // Reference model: who owns the RAM, who was served last, cycles stalled, fault seen
    int m_owner;
    int m_last;
    int m_stall;
    bit m_err;

    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_addr, e_store;

    mem_arbiter_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_owner = O_IDLE;
        m_last  = L_I;
        m_stall = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_outputs();
        e_iwait = 1'b1;
        e_dwait = 1'b1;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = 32'h0;
        e_store = 32'h0;
        if (m_owner == O_D) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_dwait = (ramstate != ACCESS);
        end else if (m_owner == O_I) begin
            e_addr  = iaddr;
            e_ren   = iREN;
            e_iwait = (ramstate != ACCESS);
        end
    endtask

    task automatic model_advance();
        bit d;
        d = dREN || dWEN;
        if (m_owner == O_IDLE) begin
            m_stall = 0;
            if (d && iREN)  m_owner = (m_last == L_I) ? O_D : O_I;
            else if (d)     m_owner = O_D;
            else if (iREN)  m_owner = O_I;
        end else if (m_owner == O_D || m_owner == O_I) begin
            bit done;
            done = (m_owner == O_D) ? !d : (!iREN || ramstate == ACCESS);
            if (ramstate == ERROR) begin
                m_owner = O_F;
            end else if (done) begin
                m_last  = (m_owner == O_D) ? L_D : L_I;
                m_owner = O_IDLE;
                m_stall = 0;
            end else if (ramstate == ACCESS) begin
                m_stall = 0;
            end else if (m_stall + 1 >= TIMEOUT) begin
                m_owner = O_F;
            end else begin
                m_stall = m_stall + 1;
            end
        end
        if (m_owner == O_F) m_err = 1'b1;
    endtask

    task automatic next_cycle();
        model_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = FREE;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        clear_inputs();
        iREN = 1'b1;
        dREN = 1'b1;
        model_reset();
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, err} !== 5'b11000 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got iw/dw/ren/wen/err=%b addr=%h store=%h exp 11000/0/0",
                     {iwait, dwait, ramREN, ramWEN, err}, ramaddr, ramstore);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        clear_inputs();
    endtask

    task automatic test_icache();
        do_reset();
        iREN = 1; iaddr = 32'h40; ramstate = FREE;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            failures++; $display("FAIL icache_c0 ren=%b iwait=%b exp 0/1", ramREN, iwait);
        end
        next_cycle(); ramstate = BUSY;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1 || ramWEN !== 1'b0) begin
            failures++; $display("FAIL icache_c1 ren=%b addr=%h iwait=%b wen=%b exp 1/40/1/0", ramREN, ramaddr, iwait, ramWEN);
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b1) begin
            failures++; $display("FAIL icache_c2_wait iwait=%b exp 1", iwait);
        end
        next_cycle(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b0 || iload !== 32'hDEADBEEF || dwait !== 1'b1) begin
            failures++; $display("FAIL icache_c3_data iwait=%b iload=%h dwait=%b exp 0/deadbeef/1", iwait, iload, dwait);
        end
        next_cycle(); ramstate = FREE; iaddr = 32'h44;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            failures++; $display("FAIL icache_c4_idle ren=%b iwait=%b exp 0/1", ramREN, iwait);
        end
        next_cycle();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
            failures++; $display("FAIL icache_regrant ren=%b addr=%h exp 1/44", ramREN, ramaddr);
        end
        iREN = 0;
        next_cycle();
    endtask

    task automatic test_dcache_fill();
        int pulses;
        logic [31:0] words [2];
        words[0] = 32'hA5A50001;
        words[1] = 32'h5A5A0002;
        pulses = 0;
        do_reset();
        dREN = 1; daddr = 32'h100;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) begin iREN = 1; iaddr = 32'h80; end
            ramstate = (c == 2 || c == 4) ? ACCESS : (c >= 5 ? FREE : BUSY);
            ramload  = (c == 4) ? words[1] : words[0];
            if (c == 3) daddr = 32'h104;
            if (c == 5) dREN = 0;
            @(negedge CLK);
            if (dwait === 1'b0) pulses++;
            checks++;
            if (iwait !== 1'b1) begin
                failures++; $display("FAIL dfill_iwait cycle=%0d iwait=%b exp 1", c, iwait);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (ramREN !== 1'b1 || ramaddr !== ((c >= 3) ? 32'h104 : 32'h100)) begin
                    failures++; $display("FAIL dfill_ram cycle=%0d ren=%b addr=%h", c, ramREN, ramaddr);
                end
            end
            if (c == 2 || c == 4) begin
                checks++;
                if (dwait !== 1'b0 || dload !== words[c/2-1]) begin
                    failures++; $display("FAIL dfill_word cycle=%0d dwait=%b dload=%h exp 0/%h", c, dwait, dload, words[c/2-1]);
                end
            end
            next_cycle();
        end
        checks++;
        if (pulses !== 2) begin
            failures++; $display("FAIL dfill_pulses got=%0d exp=2", pulses);
        end
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
            failures++; $display("FAIL dfill_then_icache ren=%b addr=%h exp 1/80", ramREN, ramaddr);
        end
        iREN = 0;
        next_cycle();
    endtask

    task automatic test_dcache_write();
        do_reset();
        dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'h12345678;
        next_cycle(); ramstate = BUSY;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) ramstate = ACCESS;
            @(negedge CLK);
            checks++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'h12345678 ||
                dwait !== (c != 3)) begin
                failures++;
                $display("FAIL dwrite cycle=%0d wen=%b ren=%b addr=%h store=%h dwait=%b", c, ramWEN, ramREN, ramaddr, ramstore, dwait);
            end
            next_cycle();
        end
        dWEN = 0; dREN = 0; ramstate = FREE;
        @(negedge CLK);
        checks++;
        if (dwait !== 1'b1 || ramWEN !== 1'b0) begin
            failures++; $display("FAIL dwrite_release dwait=%b wen=%b exp 1/0", dwait, ramWEN);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        do_reset();
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h300;
        next_cycle(); ramstate = ACCESS; ramload = 32'h0BADF00D;
        @(negedge CLK);
        checks++;
        if (ramaddr !== 32'h300 || dwait !== 1'b0 || iwait !== 1'b1) begin
            failures++; $display("FAIL contend_dfirst addr=%h dwait=%b iwait=%b exp 300/0/1", ramaddr, dwait, iwait);
        end
        next_cycle(); dREN = 0; ramstate = FREE;
        next_cycle(); dREN = 1;
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b0) begin
            failures++; $display("FAIL contend_idle ren=%b exp 0", ramREN);
        end
        next_cycle(); ramstate = ACCESS;
        @(negedge CLK);
        checks++;
        if (ramaddr !== 32'h80 || iwait !== 1'b0 || dwait !== 1'b1) begin
            failures++; $display("FAIL contend_ithen addr=%h iwait=%b dwait=%b exp 80/0/1", ramaddr, iwait, dwait);
        end
        iREN = 0; dREN = 0; ramstate = FREE;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        dREN = 1; daddr = 32'h500; ramstate = BUSY;
        next_cycle();
        for (int k = 1; k <= 64; k++) begin
            @(negedge CLK);
            checks++;
            if (err !== 1'b0 || ramREN !== 1'b1) begin
                failures++; $display("FAIL timeout_early k=%0d err=%b ren=%b exp 0/1", k, err, ramREN);
            end
            next_cycle();
        end
        ramstate = ACCESS;
        @(negedge CLK);
        checks++;
        if (err !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin
            failures++; $display("FAIL timeout_fault err=%b ren=%b wen=%b dwait=%b iwait=%b exp 1/0/0/1/1",
                                 err, ramREN, ramWEN, dwait, iwait);
        end
        do_reset();
        @(negedge CLK);
        checks++;
        if (err !== 1'b0 || ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin
            failures++; $display("FAIL timeout_recover err=%b ren=%b exp 0/0", err, ramREN);
        end
    endtask

    task automatic test_ram_error();
        do_reset();
        iREN = 1; iaddr = 32'h90;
        next_cycle(); ramstate = ERROR;
        @(negedge CLK);
        checks++;
        if (iwait !== 1'b1 || err !== 1'b0 || ramREN !== 1'b1) begin
            failures++; $display("FAIL error_cycle iwait=%b err=%b ren=%b exp 1/0/1", iwait, err, ramREN);
        end
        next_cycle(); iREN = 0; dREN = 1; daddr = 32'h600; ramstate = ACCESS;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++;
            if (err !== 1'b1 || ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin
                failures++; $display("FAIL error_fault k=%0d err=%b ren=%b dwait=%b", k, err, ramREN, dwait);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        dWEN = 1; daddr = 32'h700; dstore = 32'hCAFE0000; ramstate = BUSY;
        next_cycle();
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        checks++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h0) begin
            failures++; $display("FAIL reset_mid wen=%b ren=%b dwait=%b addr=%h exp 0/0/1/0", ramWEN, ramREN, dwait, ramaddr);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        clear_inputs();
        model_reset();
    endtask

    task automatic test_random();
        int fault_cycles;
        int r;
        fault_cycles = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            iREN   = ($urandom_range(0, 2) == 0);
            dREN   = ($urandom_range(0, 2) == 0);
            dWEN   = ($urandom_range(0, 4) == 0);
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            r = int'($urandom_range(0, 299));
            ramstate = (r == 0) ? ERROR : (r < 120 ? BUSY : (r < 200 ? ACCESS : FREE));
            @(negedge CLK);
            model_outputs();
            checks++;
            if ({iwait, dwait, ramREN, ramWEN, err} !== {e_iwait, e_dwait, e_ren, e_wen, m_err} ||
                ramaddr !== e_addr || (m_owner != O_I && ramstore !== e_store) ||
                iload !== ramload || dload !== ramload) begin
                failures++;
                $display("FAIL random n=%0d got iw/dw/ren/wen/err=%b addr=%h store=%h exp %b addr=%h store=%h",
                         n, {iwait, dwait, ramREN, ramWEN, err}, ramaddr, ramstore,
                         {e_iwait, e_dwait, e_ren, e_wen, m_err}, e_addr, e_store);
            end
            next_cycle();
            fault_cycles = (m_owner == O_F) ? fault_cycles + 1 : 0;
            if (fault_cycles > 3) begin
                do_reset();
                fault_cycles = 0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_icache();
        test_dcache_fill();
        test_dcache_write();
        test_contention();
        test_timeout();
        test_ram_error();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Responder end of the cache-to-memory request protocol (xREN/xWEN/xaddr/xstore in; xwait/xload out).
- Arbitrates instruction-cache and data-cache requests onto one single-port RAM interface.
- Holds a grant for the full span of a requester's access, so two-word dcache block fills and writebacks are never split.
- Detects RAM errors and timeouts; sits between the icache/dcache and the RAM model.

Parameters:
TIMEOUT, 64, cycles a granted access may wait for ramstate ACCESS before fault
CNT_W, 7, width of timeout counter (must hold TIMEOUT)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  icache stall; low for exactly the cycle iload is valid
iload  out  32  icache read data
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  dcache stall; low on the completing cycle
dload  out  32  dcache read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
err  out  1  sticky fault flag

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is CLK.
- Reset values: state IDLE, last_grant=I, timeout count 0, err=0. Outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- States: IDLE, DGRANT, IGRANT, FAULT. The grant is registered, so a request is first visible to the RAM one cycle after it is asserted.
- IDLE:
  - No RAM enables asserted; both waits high.
  - If only dcache requests (dREN|dWEN), go to DGRANT. If only iREN, go to IGRANT.
  - If both request, round-robin: grant the side not equal to last_grant.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted).
  - dload=ramload; dwait=(ramstate!=ACCESS); iwait=1.
  - Grant is held while dREN|dWEN, including across address changes between words.
  - When dREN=dWEN=0, go to IDLE and set last_grant=D.
- IGRANT:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0; iload=ramload; iwait=(ramstate!=ACCESS); dwait=1.
  - Single-word grant: on the ACCESS cycle, or if iREN drops, go to IDLE and set last_grant=I.
- Timeout counter:
  - Counts cycles in DGRANT/IGRANT since the last ACCESS cycle.
  - Clears on ACCESS and on any return to IDLE.
- FAULT entry: from a granted state when ramstate==ERROR or the count reaches TIMEOUT-1 without ACCESS.
- FAULT:
  - err=1; all RAM enables 0; both waits held high.
  - Exited only by reset.
- Waits and loads are combinational from state and ramstate. A wait goes low only in the owner's grant state.
- Non-owner load outputs are driven with ramload but qualified by wait high.
- Simultaneous request drop and ACCESS: the access completes (wait low) and the state goes to IDLE the same edge.
- Reset mid-access: the next cycle is IDLE with enables deasserted; the partial RAM write is the RAM's concern.

Test Plan:
- Icache alone: iREN=1, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF.
  -> ramREN rises cycle 1; iwait=0 and iload=0xDEADBEEF on cycle 3; state IDLE on cycle 4.
- Dcache two-word fill: dREN held; daddr=0x100 then 0x104 after the first ACCESS.
  -> grant stays DGRANT across both words; two dwait-low pulses; iREN asserted meanwhile sees iwait=1 throughout.
- Dcache write: dWEN=1, daddr=0x200, dstore=0x12345678.
  -> ramWEN=1, ramaddr=0x200, ramstore=0x12345678 until ACCESS; dwait low one cycle.
- Contention: iREN and dREN rise together from reset (last_grant=I).
  -> dcache served first; then icache served next, even if the dcache re-requests immediately.
- Timeout: grant dcache, hold ramstate=BUSY for 64 cycles.
  -> err=1 and FAULT on cycle 64 after grant; enables 0; waits stay high; nRST pulse returns err=0 and state IDLE.
- RAM ERROR: ramstate=3 during IGRANT.
  -> FAULT next edge, err=1; a later dREN is never granted.
